// File: rtl/ct_ciu_snb_age_matrix_pkg.sv
// Shared definitions for the CIU snoop-buffer age matrix.
//   SNB_ENTRY       : number of snoop-buffer entries (age vector width)
//   SNB_CNT_W       : width of the valid-entry counter (holds 0..SNB_ENTRY)
//   SNB_SLICE*_HI   : exclusive upper bounds of the three 8-entry slices that
//                     the downstream oldest-first select stages consume
package ct_ciu_snb_age_matrix_pkg;

  localparam int SNB_ENTRY     = 24;
  localparam int SNB_CNT_W     = 5;

  localparam int SNB_SLICE0_HI = 8;
  localparam int SNB_SLICE1_HI = 16;
  localparam int SNB_SLICE2_HI = 24;

  typedef logic [SNB_ENTRY-1:0] snb_vec_t;

endpackage

// File: rtl/ct_ciu_snb_age_entry.sv
// One snoop-buffer entry: valid flag plus its age row.
//   ciuclk, cpurst_b : clock, asynchronous active-low reset
//   create_sel       : this entry is allocated this cycle
//   pop              : this entry retires this cycle (ignored when invalid)
//   vld_nopop        : global entry_vld & ~pop; becomes the new age row
//   col_clr          : columns to clear in this row (popped + newly created)
//   vld, age         : registered valid flag and age row
module ct_ciu_snb_age_entry
  import ct_ciu_snb_age_matrix_pkg::*;
#(
  parameter int ENTRY = SNB_ENTRY
) (
  input  logic             ciuclk,
  input  logic             cpurst_b,
  input  logic             create_sel,
  input  logic             pop,
  input  logic [ENTRY-1:0] vld_nopop,
  input  logic [ENTRY-1:0] col_clr,
  output logic             vld,
  output logic [ENTRY-1:0] age
);

  // A freshly created entry is youngest: every entry still valid after this
  // cycle's pops is older. Its own bit is zero because it was free.
  // Create takes priority; a created entry was invalid, so a pop aimed at it
  // in the same cycle is a pop of an invalid entry and must be ignored.
  always_ff @(posedge ciuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      vld <= 1'b0;
      age <= '0;
    end else if (create_sel) begin
      vld <= 1'b1;
      age <= vld_nopop;
    end else if (pop && vld) begin
      vld <= 1'b0;
      age <= '0;
    end else begin
      age <= age & ~col_clr;
    end
  end

endmodule

// File: rtl/ct_ciu_snb_age_matrix.sv
// Allocation-order tracker for the 24 CIU snoop-buffer entries.
//   ciuclk, cpurst_b : clock, asynchronous active-low reset
//   snb_create_req   : new snoop wants an entry
//   snb_create_gnt   : comb; request accepted (a free entry exists)
//   snb_create_ptr   : comb; one-hot lowest free entry, zero when not granted
//   snb_pop_vld      : entries retiring this cycle (multi-hot)
//   entry_vld        : registered per-entry valid
//   age_vect_flat    : registered age rows, entry i at [i*ENTRY +: ENTRY];
//                      bit j set means entry j is older than entry i
//   snb_full/empty   : registered occupancy flags
//   vld_cnt          : registered number of valid entries
module ct_ciu_snb_age_matrix
  import ct_ciu_snb_age_matrix_pkg::*;
#(
  parameter int ENTRY = SNB_ENTRY,
  parameter int CNT_W = SNB_CNT_W
) (
  input  logic                   ciuclk,
  input  logic                   cpurst_b,
  input  logic                   snb_create_req,
  output logic                   snb_create_gnt,
  output logic [ENTRY-1:0]       snb_create_ptr,
  input  logic [ENTRY-1:0]       snb_pop_vld,
  output logic [ENTRY-1:0]       entry_vld,
  output logic [ENTRY*ENTRY-1:0] age_vect_flat,
  output logic                   snb_full,
  output logic                   snb_empty,
  output logic [CNT_W-1:0]       vld_cnt
);

  logic [ENTRY-1:0] free_vec;
  logic [ENTRY-1:0] first_free;
  logic [ENTRY-1:0] vld_nopop;
  logic [ENTRY-1:0] col_clr;
  logic [ENTRY-1:0] vld_next;
  logic [CNT_W-1:0] cnt_next;
  logic [ENTRY-1:0] age_row [ENTRY];

  // Popped entries stay occupied until the next cycle.
  assign free_vec   = ~entry_vld;
  // Isolate the lowest set bit: x & -x.
  assign first_free = free_vec & (~free_vec + ENTRY'(1));

  assign snb_create_gnt = snb_create_req & (|free_vec);
  assign snb_create_ptr = snb_create_gnt ? first_free : '0;

  assign vld_nopop = entry_vld & ~snb_pop_vld;
  assign col_clr   = snb_pop_vld | snb_create_ptr;
  assign vld_next  = vld_nopop | snb_create_ptr;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRY; gi++) begin : g_entry
      ct_ciu_snb_age_entry #(.ENTRY(ENTRY)) u_entry (
        .ciuclk     (ciuclk),
        .cpurst_b   (cpurst_b),
        .create_sel (snb_create_ptr[gi]),
        .pop        (snb_pop_vld[gi]),
        .vld_nopop  (vld_nopop),
        .col_clr    (col_clr),
        .vld        (entry_vld[gi]),
        .age        (age_row[gi])
      );

      assign age_vect_flat[gi*ENTRY +: ENTRY] = age_row[gi];

      // Valid rows only reference valid entries; invalid rows are empty.
      a_age_subset : assert property (@(posedge ciuclk) disable iff (!cpurst_b)
        entry_vld[gi] ? ((age_row[gi] & ~entry_vld) == '0) : (age_row[gi] == '0));
    end
  endgenerate

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < ENTRY; i++) begin
      cnt_next = cnt_next + CNT_W'(vld_next[i]);
    end
  end

  always_ff @(posedge ciuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      vld_cnt   <= '0;
      snb_full  <= 1'b0;
      snb_empty <= 1'b1;
    end else begin
      vld_cnt   <= cnt_next;
      snb_full  <= &vld_next;
      snb_empty <= ~(|vld_next);
    end
  end

  a_full_empty : assert property (@(posedge ciuclk) disable iff (!cpurst_b)
    !(snb_full && snb_empty));

endmodule

// File: tb/tb_ct_ciu_snb_age_matrix.sv
module tb_ct_ciu_snb_age_matrix;

  localparam int N = 24;

  logic           ciuclk = 1'b0;
  logic           cpurst_b;
  logic           snb_create_req;
  logic           snb_create_gnt;
  logic [N-1:0]   snb_create_ptr;
  logic [N-1:0]   snb_pop_vld;
  logic [N-1:0]   entry_vld;
  logic [N*N-1:0] age_vect_flat;
  logic           snb_full;
  logic           snb_empty;
  logic [4:0]     vld_cnt;

  ct_ciu_snb_age_matrix dut (
    .ciuclk         (ciuclk),
    .cpurst_b       (cpurst_b),
    .snb_create_req (snb_create_req),
    .snb_create_gnt (snb_create_gnt),
    .snb_create_ptr (snb_create_ptr),
    .snb_pop_vld    (snb_pop_vld),
    .entry_vld      (entry_vld),
    .age_vect_flat  (age_vect_flat),
    .snb_full       (snb_full),
    .snb_empty      (snb_empty),
    .vld_cnt        (vld_cnt)
  );

  always #5 ciuclk = ~ciuclk;

  typedef struct {
    logic [N-1:0]   vld;
    logic [N*N-1:0] age;
    logic [4:0]     cnt;
    logic           full;
    logic           empty;
  } exp_t;

  exp_t         sb_q[$];
  logic [N-1:0] m_vld;
  logic [N-1:0] m_age [N];
  logic [N-1:0] dut_ptr;
  int           n_checks = 0;
  int           n_errors = 0;
  int           n_txn    = 0;

  task automatic check(input string tag, input logic [N*N-1:0] obs, input logic [N*N-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*N-1:0] m_flat();
    logic [N*N-1:0] f;
    for (int i = 0; i < N; i++) f[i*N +: N] = m_age[i];
    return f;
  endfunction

  task automatic model_reset();
    m_vld = '0;
    for (int i = 0; i < N; i++) m_age[i] = '0;
  endtask

  // One clock of stimulus: check combinational grant against the model,
  // advance the model, queue the expected registered state, compare after the edge.
  task automatic step(input logic req, input logic [N-1:0] pop);
    logic [N-1:0] e_ptr;
    logic [N-1:0] survivors;
    exp_t e;
    exp_t got;
    @(negedge ciuclk);
    snb_create_req = req;
    snb_pop_vld    = pop;
    #1;
    e_ptr = '0;
    for (int i = 0; i < N; i++)
      if (req && !m_vld[i] && e_ptr == '0) e_ptr[i] = 1'b1;
    check("gnt", N*N'(snb_create_gnt), N*N'(|e_ptr));
    check("ptr", N*N'(snb_create_ptr), N*N'(e_ptr));
    dut_ptr = snb_create_ptr;

    survivors = m_vld & ~pop;
    for (int x = 0; x < N; x++) begin
      if (pop[x] && m_vld[x]) begin
        m_age[x] = '0;
        for (int r = 0; r < N; r++) m_age[r][x] = 1'b0;
      end
    end
    m_vld = survivors;
    for (int y = 0; y < N; y++) begin
      if (e_ptr[y]) begin
        m_age[y] = survivors;
        m_vld[y] = 1'b1;
      end
    end
    e.vld   = m_vld;
    e.age   = m_flat();
    e.cnt   = 5'($countones(m_vld));
    e.full  = (m_vld == '1);
    e.empty = (m_vld == '0);
    sb_q.push_back(e);

    @(posedge ciuclk);
    #1;
    got = sb_q.pop_front();
    check("entry_vld", N*N'(entry_vld), N*N'(got.vld));
    check("age_flat", age_vect_flat, got.age);
    check("vld_cnt", N*N'(vld_cnt), N*N'(got.cnt));
    check("full", N*N'(snb_full), N*N'(got.full));
    check("empty", N*N'(snb_empty), N*N'(got.empty));
    n_txn++;
    $display("txn %0d req=%0b pop=%06h ptr=%06h vld=%06h cnt=%0d", n_txn, req, pop,
             dut_ptr, entry_vld, vld_cnt);
  endtask

  function automatic logic [N-1:0] row(input int i);
    return age_vect_flat[i*N +: N];
  endfunction

  initial begin
    cpurst_b       = 1'b0;
    snb_create_req = 1'b0;
    snb_pop_vld    = '0;
    model_reset();
    #12;
    check("rst_vld", N*N'(entry_vld), '0);
    check("rst_age", age_vect_flat, '0);
    check("rst_cnt", N*N'(vld_cnt), '0);
    check("rst_empty", N*N'(snb_empty), N*N'(1'b1));
    check("rst_full", N*N'(snb_full), '0);
    check("rst_gnt", N*N'(snb_create_gnt), '0);
    @(negedge ciuclk);
    cpurst_b = 1'b1;

    // Three creates in a row.
    step(1'b1, '0); check("plan_ptr0", N*N'(dut_ptr), N*N'(24'h000001));
    step(1'b1, '0); check("plan_ptr1", N*N'(dut_ptr), N*N'(24'h000002));
    step(1'b1, '0); check("plan_ptr2", N*N'(dut_ptr), N*N'(24'h000004));
    check("plan_age0", N*N'(row(0)), '0);
    check("plan_age1", N*N'(row(1)), N*N'(24'h000001));
    check("plan_age2", N*N'(row(2)), N*N'(24'h000003));
    check("plan_cnt3", N*N'(vld_cnt), N*N'(5'd3));

    // Pop 0 and create together: entry 0 not yet reusable.
    step(1'b1, 24'h000001);
    check("plan_ptr3", N*N'(dut_ptr), N*N'(24'h000008));
    check("plan_age3", N*N'(row(3)), N*N'(24'h000006));
    check("plan_age1b", N*N'(row(1)), '0);
    check("plan_age2b", N*N'(row(2)), N*N'(24'h000002));
    check("plan_cnt_keep", N*N'(vld_cnt), N*N'(5'd3));

    // Fill to full, then one rejected create.
    for (int k = 0; k < 21; k++) step(1'b1, '0);
    check("plan_full", N*N'(snb_full), N*N'(1'b1));
    check("plan_cnt24", N*N'(vld_cnt), N*N'(5'd24));
    step(1'b1, '0);
    check("plan_full_ptr", N*N'(dut_ptr), '0);

    // Pop 5 and 17 together, then create.
    step(1'b0, 24'h020020);
    check("plan_cnt22", N*N'(vld_cnt), N*N'(5'd22));
    check("plan_notfull", N*N'(snb_full), '0);
    step(1'b1, '0);
    check("plan_ptr5", N*N'(dut_ptr), N*N'(24'h000020));
    check("plan_age5", N*N'(row(5)), N*N'(24'hFDFFDF));

    // Pop entry 23, then pop it again while invalid.
    step(1'b0, 24'h800000);
    step(1'b0, 24'h800000);
    check("plan_inv_pop_cnt", N*N'(vld_cnt), N*N'(5'd22));

    // Random traffic.
    for (int k = 0; k < 150; k++)
      step(1'($urandom_range(0, 1)), N'($urandom & $urandom & $urandom));

    // Drain, create 10, then asynchronous reset between edges.
    step(1'b0, '1);
    for (int k = 0; k < 10; k++) step(1'b1, '0);
    check("plan_cnt10", N*N'(vld_cnt), N*N'(5'd10));
    @(negedge ciuclk);
    snb_create_req = 1'b0;
    snb_pop_vld    = '0;
    #1;
    cpurst_b = 1'b0;
    #1;
    model_reset();
    check("arst_vld", N*N'(entry_vld), '0);
    check("arst_age", age_vect_flat, '0);
    check("arst_empty", N*N'(snb_empty), N*N'(1'b1));
    check("arst_cnt", N*N'(vld_cnt), '0);
    @(negedge ciuclk);
    cpurst_b = 1'b1;
    step(1'b1, '0);
    check("arst_ptr", N*N'(dut_ptr), N*N'(24'h000001));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
